// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 ("double dabble").
// One input bit is consumed per clock. The packed BCD result drives the
// per-digit 7-segment decoders of the score display.
//
// Parameters:
//   BIN_W  - width of the binary input; also the conversion length in cycles
//   DIGITS - number of BCD output digits (max value 10^DIGITS - 1)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, accepted only while busy = 0
//   bin      in   [BIN_W-1:0] binary value, sampled on the accepting edge
//   busy     out  conversion in progress
//   done     out  one-cycle strobe; bcd/overflow updated on the same edge
//   bcd      out  [4*DIGITS-1:0] packed digits, digit 0 = ones in [3:0]
//   overflow out  last accepted value exceeded 10^DIGITS - 1
//   blank    out  [DIGITS-1:0] leading-zero blank mask
//                 (only when BCD_BLANK_EN is defined)
//
// Build option:
//   BCD_BLANK_EN - adds the registered leading-zero blank mask output.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Smallest value that no longer fits in DIGITS decimal digits.
    localparam logic [63:0] LIMIT = pow10(DIGITS);

`ifdef BCD_BLANK_EN
    // Reset mask: every digit blanked except the ones digit, so "0" shows.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [SCR_W-1:0]   scratch_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               ovf_flag_reg;

    logic [SCR_W-1:0]   scratch_next;
    logic [DIGITS-1:0]  ge5;
    logic [DIGITS-1:0]  carry_in;
    logic               ovf_in;

    assign ovf_in = 64'(bin) >= LIMIT;

    // The bit shifted into the ones digit comes from the top of the binary
    // register; each higher digit receives the top bit of the adjusted digit
    // below it.
    assign carry_in[0] = bin_reg[BIN_W-1];

    // Add-3-then-shift per digit. For any legal digit (0..9) the adjusted
    // value's bit 3 equals (digit >= 5), so that comparison doubles as the
    // carry into the next digit and only the low three adjusted bits are
    // needed. The top digit's carry out is simply dropped; overflow
    // saturation covers that case.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            logic [2:0] low3;
            assign digit   = scratch_reg[4*gi +: 4];
            assign ge5[gi] = (digit >= 4'd5);
            assign low3    = ge5[gi] ? (digit[2:0] + 3'd3) : digit[2:0];
            assign scratch_next[4*gi +: 4] = {low3, carry_in[gi]};
            if (gi < DIGITS - 1) begin : g_carry
                assign carry_in[gi+1] = ge5[gi];
            end
        end
    endgenerate

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;

    // A digit is blanked when it and every digit above it are zero; the
    // ones digit is never blanked.
    assign blank_next[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_next[gi] = ~|scratch_next[SCR_W-1:4*gi];
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            scratch_reg  <= '0;
            count_reg    <= '0;
            ovf_flag_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bcd          <= '0;
            overflow     <= 1'b0;
`ifdef BCD_BLANK_EN
            blank        <= BLANK_RST;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg      <= bin;
                        scratch_reg  <= '0;
                        count_reg    <= '0;
                        ovf_flag_reg <= ovf_in;
                        busy         <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= scratch_next;
                    bin_reg     <= bin_reg << 1;
                    count_reg   <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        overflow  <= ovf_flag_reg;
                        state_reg <= IDLE;
                        if (ovf_flag_reg) begin
                            bcd <= {DIGITS{4'h9}};
                        end else begin
                            bcd <= scratch_next;
                        end
`ifdef BCD_BLANK_EN
                        if (ovf_flag_reg) begin
                            blank <= '0;
                        end else begin
                            blank <= blank_next;
                        end
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Two instances: dut_a (BIN_W=8, DIGITS=3) and dut_b (BIN_W=8, DIGITS=2, for
// overflow/saturation). A behavioural model computes the expected outputs
// with plain decimal arithmetic and a cycle countdown; a compare process
// checks every output against it on every falling edge. Directed
// transactions additionally pin results to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start_s [2];
    logic [7:0]  bin_s   [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        ovf_s   [2];
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [11:0] bcd_w   [2];
    logic [2:0]  blank_w [2];

    assign bcd_w[0] = bcd_a;
    assign bcd_w[1] = {4'h0, bcd_b};

`ifdef BCD_BLANK_EN
    logic [2:0] blank_a;
    logic [1:0] blank_b;
    assign blank_w[0] = blank_a;
    assign blank_w[1] = {1'b0, blank_b};
`else
    assign blank_w[0] = 3'b000;
    assign blank_w[1] = 3'b000;
`endif

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s[0]),
        .bin      (bin_s[0]),
        .busy     (busy_s[0]),
        .done     (done_s[0]),
        .bcd      (bcd_a),
        .overflow (ovf_s[0])
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank_a)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s[1]),
        .bin      (bin_s[1]),
        .busy     (busy_s[1]),
        .done     (done_s[1]),
        .bcd      (bcd_b),
        .overflow (ovf_s[1])
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int digs_of(input int j);
        return (j == 0) ? 3 : 2;
    endfunction

    function automatic int p10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [11:0] f_bcd(input int v, input int d);
        logic [11:0] r = '0;
        for (int i = 0; i < d; i++) begin
            if (v >= p10(d)) r[4*i +: 4] = 4'd9;
            else             r[4*i +: 4] = 4'((v / p10(i)) % 10);
        end
        return r;
    endfunction

    function automatic logic [2:0] f_blank(input int v, input int d);
        logic [2:0] r = '0;
        if (v < p10(d)) begin
            for (int i = 1; i < d; i++) r[i] = (v < p10(i));
        end
        return r;
    endfunction

    logic        m_busy  [2];
    logic        m_done  [2];
    logic        m_ovf   [2];
    int          m_left  [2];
    int          m_val   [2];
    logic [11:0] m_bcd   [2];
    logic [2:0]  m_blank [2];

    always @(posedge clk or negedge rst_n) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                m_busy[j]  <= 1'b0;
                m_done[j]  <= 1'b0;
                m_ovf[j]   <= 1'b0;
                m_left[j]  <= 0;
                m_val[j]   <= 0;
                m_bcd[j]   <= '0;
                m_blank[j] <= f_blank(0, digs_of(j));
            end else begin
                m_done[j] <= 1'b0;
                if (!m_busy[j]) begin
                    if (start_s[j]) begin
                        m_busy[j] <= 1'b1;
                        m_left[j] <= 8;
                        m_val[j]  <= int'(bin_s[j]);
                    end
                end else if (m_left[j] == 1) begin
                    m_busy[j]  <= 1'b0;
                    m_done[j]  <= 1'b1;
                    m_bcd[j]   <= f_bcd(m_val[j], digs_of(j));
                    m_ovf[j]   <= (m_val[j] >= p10(digs_of(j)));
                    m_blank[j] <= f_blank(m_val[j], digs_of(j));
                end else begin
                    m_left[j] <= m_left[j] - 1;
                end
            end
        end
    end

    // Continuous compare on the falling edge.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("model_busy%0d", j), 12'(busy_s[j]), 12'(m_busy[j]));
            chk($sformatf("model_done%0d", j), 12'(done_s[j]), 12'(m_done[j]));
            chk($sformatf("model_bcd%0d", j),  bcd_w[j],        m_bcd[j]);
            chk($sformatf("model_ovf%0d", j),  12'(ovf_s[j]),   12'(m_ovf[j]));
`ifdef BCD_BLANK_EN
            chk($sformatf("model_blank%0d", j), 12'(blank_w[j]), 12'(m_blank[j]));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic start_conv(input int j, input logic [7:0] v);
        @(negedge clk); #1;
        start_s[j] = 1'b1;
        bin_s[j]   = v;
    endtask

    // Waits for done (bounded), optionally injecting a start/bin change while
    // busy, then checks the result against literals.
    task automatic wait_done(input int j, input logic [11:0] eb, input logic eo,
                             input logic [2:0] ebl, input logic pulse,
                             input int inj, input logic [7:0] iv);
        int nb   = 0;
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            start_s[j] = 1'b0;
            if (c == inj) begin
                start_s[j] = 1'b1;
                bin_s[j]   = iv;
            end
            if (done_s[j]) seen = 1;
            else if (busy_s[j]) nb++;
        end
        chk($sformatf("done_seen%0d", j), 12'(seen), 12'd1);
        chk($sformatf("bcd%0d", j), bcd_w[j], eb);
        chk($sformatf("ovf%0d", j), 12'(ovf_s[j]), 12'(eo));
        chk($sformatf("busy_cycles%0d", j), 12'(nb), 12'd8);
`ifdef BCD_BLANK_EN
        chk($sformatf("blank%0d", j), 12'(blank_w[j]), 12'(ebl));
`else
        if (ebl === 3'bxxx) $display("unexpected blank literal");
`endif
        if (pulse) begin
            @(negedge clk); #1;
            chk($sformatf("done_width%0d", j), 12'(done_s[j]), 12'd0);
        end
    endtask

    task automatic count_dones(input int j, input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk); #1;
            if (done_s[j]) cnt++;
        end
    endtask

    int          nd;
    int          vals  [8] = '{1, 9, 10, 99, 100, 128, 200, 254};
    logic [11:0] exps  [8] = '{12'h001, 12'h009, 12'h010, 12'h099,
                               12'h100, 12'h128, 12'h200, 12'h254};
    logic [2:0]  expbl [8] = '{3'b110, 3'b110, 3'b100, 3'b100,
                               3'b000, 3'b000, 3'b000, 3'b000};

    initial begin
        for (int j = 0; j < 2; j++) begin
            start_s[j] = 1'b0;
            bin_s[j]   = 8'd0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 12'(busy_s[0]), 12'd0);
        chk("rst_done", 12'(done_s[0]), 12'd0);
        chk("rst_bcd",  bcd_a, 12'h000);
        chk("rst_ovf",  12'(ovf_s[0]), 12'd0);
`ifdef BCD_BLANK_EN
        chk("rst_blank", 12'(blank_a), 12'(3'b110));
`endif
        rst_n = 1'b1;

        // Zero, then a small value.
        start_conv(0, 8'd0);
        wait_done(0, 12'h000, 1'b0, 3'b110, 1'b1, -1, 8'd0);
        start_conv(0, 8'd21);
        wait_done(0, 12'h021, 1'b0, 3'b100, 1'b1, -1, 8'd0);

        // Max input; bin changes and start pulses while busy.
        start_conv(0, 8'd255);
        wait_done(0, 12'h255, 1'b0, 3'b000, 1'b1, 3, 8'd7);
        count_dones(0, 12, nd);
        chk("no_extra_done", 12'(nd), 12'd0);

        // Back-to-back: second start in the done cycle.
        start_conv(0, 8'd99);
        wait_done(0, 12'h099, 1'b0, 3'b100, 1'b0, -1, 8'd0);
        start_s[0] = 1'b1;
        bin_s[0]   = 8'd100;
        wait_done(0, 12'h100, 1'b0, 3'b000, 1'b1, -1, 8'd0);

        // Two-digit instance: overflow saturation and recovery.
        start_conv(1, 8'd150);
        wait_done(1, 12'h099, 1'b1, 3'b000, 1'b1, -1, 8'd0);
        start_conv(1, 8'd42);
        wait_done(1, 12'h042, 1'b0, 3'b000, 1'b1, -1, 8'd0);
        start_conv(1, 8'd99);
        wait_done(1, 12'h099, 1'b0, 3'b000, 1'b1, -1, 8'd0);
        start_conv(1, 8'd100);
        wait_done(1, 12'h099, 1'b1, 3'b000, 1'b1, -1, 8'd0);
        start_conv(1, 8'd5);
        wait_done(1, 12'h005, 1'b0, 3'b010, 1'b1, -1, 8'd0);

        // Reset in the middle of a conversion.
        start_conv(0, 8'd77);
        @(negedge clk); #1;
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 12'(busy_s[0]), 12'd0);
        chk("midrst_done", 12'(done_s[0]), 12'd0);
        chk("midrst_bcd",  bcd_a, 12'h000);
        chk("midrst_ovf",  12'(ovf_s[0]), 12'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        count_dones(0, 12, nd);
        chk("no_done_after_rst", 12'(nd), 12'd0);
        start_conv(0, 8'd77);
        wait_done(0, 12'h077, 1'b0, 3'b100, 1'b1, -1, 8'd0);

        // Table of further values on the three-digit instance.
        for (int k = 0; k < 8; k++) begin
            start_conv(0, 8'(vals[k]));
            wait_done(0, exps[k], 1'b0, expbl[k], 1'b1, -1, 8'd0);
        end

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
